// File: rtl/bist_signature_analyzer_pkg.sv
// Shared constants for the BIST response compactor: default geometry,
// MISR polynomial, frame counter width and FSM state encodings.
package bist_signature_analyzer_pkg;

  localparam int                 CHAIN_LEN_DEF = 8;
  localparam int                 SIG_W_DEF     = 8;
  localparam logic [SIG_W_DEF-1:0] SIG_POLY_DEF = 8'h1D;
  localparam int                 FRAME_CNT_W   = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SHIFT   = 2'd1;
  localparam state_t ST_COMPACT = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/bist_signature_analyzer_if.sv
// Scan-side and status bundle between the BIST controller side (master)
// and the signature analyzer (slave).
interface bist_signature_analyzer_if
  import bist_signature_analyzer_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) ();

  logic                   clear;
  logic                   scan_en;
  logic                   scan_out;
  logic [SIG_W-1:0]       signature;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   frame_err;
  logic                   done;
  logic                   pass;

  modport master (
    output clear, scan_en, scan_out,
    input  signature, frame_cnt, frame_err, done, pass
  );

  modport slave (
    input  clear, scan_en, scan_out,
    output signature, frame_cnt, frame_err, done, pass
  );

endinterface

// File: rtl/bist_signature_analyzer_misr.sv
// Parallel-input MISR: each enabled cycle shifts left with polynomial
// feedback from the MSB and XORs in a full response word.
module bist_signature_analyzer_misr #(
  parameter int               SIG_W    = 8,
  parameter logic [SIG_W-1:0] SIG_POLY = 8'h1D,
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [SIG_W-1:0] i_din,
  output logic [SIG_W-1:0] o_sig,
  output logic [SIG_W-1:0] o_sigNext
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_feedback;

  assign w_feedback = r_sig[SIG_W-1] ? SIG_POLY : '0;
  assign o_sigNext  = (r_sig << 1) ^ w_feedback ^ i_din;
  assign o_sig      = r_sig;

  // Signature register: seed on reset or load, otherwise fold in when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= SIG_SEED;
    end else if (i_load) begin
      r_sig <= SIG_SEED;
    end else if (i_en) begin
      r_sig <= o_sigNext;
    end
  end

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST signature analyzer: deserializes scan_en-framed scan_out frames,
// compacts each into a MISR on the capture cycle, checks frame length and
// reports done/pass against a golden signature after a fixed frame count.
module bist_signature_analyzer
  import bist_signature_analyzer_pkg::*;
#(
  parameter int               CHAIN_LEN     = CHAIN_LEN_DEF,
  parameter int               SIG_W         = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SIG_POLY      = SIG_POLY_DEF,
  parameter logic [SIG_W-1:0] SIG_SEED      = '0,
  parameter int               NUM_FRAMES    = 16,
  parameter bit               DISCARD_FIRST = 1'b1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = '0
) (
  input logic                      clk,
  input logic                      rst,
  bist_signature_analyzer_if.slave bus
);

  localparam int BCW = $clog2(CHAIN_LEN + 2);
  localparam logic [BCW-1:0]         BIT_FULL   = BCW'(CHAIN_LEN);
  localparam logic [BCW-1:0]         BIT_SAT    = BCW'(CHAIN_LEN + 1);
  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_MAX  = FRAME_CNT_W'(NUM_FRAMES);

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CHAIN_LEN-1:0]   r_word;
  logic [CHAIN_LEN:0]     w_wordWide;
  logic [BCW-1:0]         r_bitCnt;
  logic [FRAME_CNT_W-1:0] r_frameCnt;
  logic                   r_frameErr;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_discard;
  logic                   w_shift;
  logic                   w_capture;
  logic                   w_compact;
  logic                   w_lastFrame;
  logic                   w_frameErrNext;
  logic [SIG_W-1:0]       w_sig;
  logic [SIG_W-1:0]       w_sigNext;
  logic [SIG_W-1:0]       w_din;

  // Shifting stops once the run is complete; capture is the first low
  // scan_en cycle after at least one shifted bit.
  assign w_shift        = bus.scan_en && (r_state != ST_DONE);
  assign w_capture      = !bus.scan_en && (r_state == ST_SHIFT) && (r_bitCnt != '0);
  assign w_compact      = w_capture && !r_discard;
  assign w_lastFrame    = w_compact && (r_frameCnt == LAST_FRAME);
  assign w_frameErrNext = r_frameErr | (w_capture && (r_bitCnt != BIT_FULL));
  assign w_wordWide     = {r_word, bus.scan_out};
  assign w_din          = SIG_W'(r_word);

  bist_signature_analyzer_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (bus.clear),
    .i_en      (w_compact),
    .i_din     (w_din),
    .o_sig     (w_sig),
    .o_sigNext (w_sigNext)
  );

  // Next-state logic; the final compaction jumps straight to DONE so that
  // done rises on the same edge as the last signature update.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (bus.scan_en) w_stateNext = ST_SHIFT;
      ST_SHIFT:   if (!bus.scan_en) w_stateNext = w_lastFrame ? ST_DONE : ST_COMPACT;
      ST_COMPACT: w_stateNext = bus.scan_en ? ST_SHIFT : ST_IDLE;
      ST_DONE:    w_stateNext = ST_DONE;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  // State register; clear behaves like a one-cycle synchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (bus.clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Deserializer: first bit shifted in ends up in the MSB; the word and the
  // bit counter are emptied on the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word   <= '0;
      r_bitCnt <= '0;
    end else if (bus.clear) begin
      r_word   <= '0;
      r_bitCnt <= '0;
    end else if (w_shift) begin
      r_word <= w_wordWide[CHAIN_LEN-1:0];
      if (r_bitCnt != BIT_SAT) r_bitCnt <= r_bitCnt + BCW'(1);
    end else if (w_capture) begin
      r_word   <= '0;
      r_bitCnt <= '0;
    end
  end

  // Frame accounting: discard of the reset-state unload, sticky length
  // error, compacted frame count and the final pass/fail verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameCnt <= '0;
      r_frameErr <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_discard  <= DISCARD_FIRST;
    end else if (bus.clear) begin
      r_frameCnt <= '0;
      r_frameErr <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_discard  <= DISCARD_FIRST;
    end else begin
      if (w_capture) begin
        r_frameErr <= w_frameErrNext;
        r_discard  <= 1'b0;
      end
      if (w_compact && (r_frameCnt != FRAME_MAX)) r_frameCnt <= r_frameCnt + FRAME_CNT_W'(1);
      if (w_lastFrame) begin
        r_done <= 1'b1;
        r_pass <= (w_sigNext == GOLDEN_SIG) && !w_frameErrNext;
      end
    end
  end

  assign bus.signature = w_sig;
  assign bus.frame_cnt = r_frameCnt;
  assign bus.frame_err = r_frameErr;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;

endmodule
